// File: rtl/imm_extend_fifo.sv
// Immediate extender (sign/zero/upper/branch) feeding a DEPTH-entry FIFO.
// Define IMM_EXT_BRANCH_EN to give mode 11 its branch meaning (sign-extend, then <<2).
module imm_extend_fifo #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [1:0]                 in_mode,
   input  logic [IN_W-1:0]            in_imm,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [OUT_W-1:0]           out_data,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH+1);
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

   if (IN_W < 2 || IN_W >= OUT_W) begin : g_width_check
      $error("imm_extend_fifo: need 2 <= IN_W < OUT_W");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
      $error("imm_extend_fifo: DEPTH must be a power of 2 and >= 2");
   end
`ifdef IMM_EXT_BRANCH_EN
   if (OUT_W < IN_W + 2) begin : g_branch_check
      $error("imm_extend_fifo: branch mode needs OUT_W >= IN_W+2");
   end
`endif

   function automatic logic [OUT_W-1:0] extend(input logic [1:0] mode, input logic [IN_W-1:0] imm);
      logic signed [OUT_W-1:0] sext;
      sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
      case (mode)
         2'b01:   extend = {{(OUT_W-IN_W){1'b0}}, imm};
         2'b10:   extend = {imm, {(OUT_W-IN_W){1'b0}}};
`ifdef IMM_EXT_BRANCH_EN
         2'b11:   extend = {sext[OUT_W-3:0], 2'b00};
`endif
         default: extend = sext;
      endcase
   endfunction

   logic [OUT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push;
   logic             pop;

   assign in_ready  = (level != FULL_LVL);
   assign out_valid = (level != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   // Head read straight from storage; an entry is only visible the cycle after its push edge.
   assign out_data  = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= extend(in_mode, in_imm);
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      level <= level + 1'b1;
         else if (!push && pop) level <= level - 1'b1;
      end
   end

endmodule

// File: tb/tb_imm_extend_fifo.sv
// Directed bench for imm_extend_fifo: queue model checked every cycle plus literal expectations.
module tb_imm_extend_fifo;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_mode = 2'b00;
   logic [15:0] in_imm = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [2:0]  level;

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;
   bit last_push, last_pop;
   bit m_push, m_pop;
   logic [31:0] mq[$];
   logic [31:0] pushed[$];
   logic [31:0] popped[$];

   imm_extend_fifo #(.IN_W(16), .OUT_W(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_mode(in_mode), .in_imm(in_imm), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .level(level)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_ext(input logic [1:0] m, input logic [15:0] v);
      int s;
      s = int'($signed(v));
      case (m)
         2'd0: return s;
         2'd1: return 32'(v);
         2'd2: return 32'(v) << 16;
`ifdef IMM_EXT_BRANCH_EN
         default: return s << 2;
`else
         default: return s;
`endif
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: FIFO as a queue of already-extended values.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) mq.delete();
      else begin
         m_pop  = out_ready && (mq.size() > 0);
         m_push = in_valid && (mq.size() < DEPTH);
         if (m_pop) void'(mq.pop_front());
         if (m_push) mq.push_back(ref_ext(in_mode, in_imm));
      end
   end

   always @(negedge clk) begin
      if (rst_n && mon_en) begin
         chk("mon_out_valid", 32'(out_valid), 32'(mq.size() != 0));
         chk("mon_in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
         chk("mon_level", 32'(level), 32'(mq.size()));
         if (mq.size() != 0) chk("mon_out_data", out_data, mq[0]);
      end
   end

   task automatic step(input bit iv, input logic [1:0] m, input logic [15:0] v, input bit ordy);
      @(negedge clk);
      in_valid  = iv;
      in_mode   = m;
      in_imm    = v;
      out_ready = ordy;
      last_push = iv && in_ready;
      last_pop  = ordy && out_valid;
      if (last_push) pushed.push_back(ref_ext(m, v));
      if (last_pop) popped.push_back(out_data);
      @(posedge clk);
      #1;
   endtask

   logic [31:0] mode_lit [4];
   int sent, cycles;

   initial begin
      mode_lit[0] = 32'hFFFFFDFF;
      mode_lit[1] = 32'h0000FDFF;
      mode_lit[2] = 32'hFDFF0000;
`ifdef IMM_EXT_BRANCH_EN
      mode_lit[3] = 32'hFFFFF7FC;
`else
      mode_lit[3] = 32'hFFFFFDFF;
`endif
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      mon_en = 1'b1;

      // Latency: push at edge N, visible right after it
      step(1, 2'd0, 16'h7FFF, 0);
      chk("lat_out_valid", 32'(out_valid), 32'd1);
      chk("lat_out_data", out_data, 32'h00007FFF);
      chk("lat_level", 32'(level), 32'd1);
      step(0, 2'd0, 16'h0, 1);
      chk("lat_drained", 32'(level), 32'd0);

      // All four modes on 0xFDFF
      for (int i = 0; i < 4; i++) step(1, 2'(i), 16'hFDFF, 0);
      chk("modes_full", 32'(in_ready), 32'd0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("mode%0d_data", i), out_data, mode_lit[i]);
         step(0, 2'd0, 16'h0, 1);
      end

      // Full / backpressure: 5 pushes, 5th refused
      for (int i = 0; i < 5; i++) begin
         step(1, 2'd1, 16'h1000 + 16'(i), 0);
         if (i == 3) chk("full_in_ready", 32'(in_ready), 32'd0);
      end
      chk("full_5th_refused", 32'(last_push), 32'd0);
      chk("full_level", 32'(level), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("full_pop%0d", i), out_data, 32'h1000 + 32'(i));
         step(0, 2'd0, 16'h0, 1);
         chk($sformatf("full_ready%0d", i), 32'(in_ready), 32'd1);
      end

      // Simultaneous push+pop at level 2
      step(1, 2'd1, 16'h00AA, 0);
      step(1, 2'd1, 16'h00BB, 0);
      step(1, 2'd0, 16'h8001, 1);
      chk("simul_level", 32'(level), 32'd2);
      chk("simul_head", out_data, 32'h000000BB);
      step(0, 2'd0, 16'h0, 1);
      chk("simul_tail", out_data, 32'hFFFF8001);
      step(0, 2'd0, 16'h0, 1);
      chk("simul_empty", 32'(out_valid), 32'd0);

      // Wrap: 3*DEPTH+1 values with random out_ready
      pushed.delete();
      popped.delete();
      sent = 0;
      cycles = 0;
      while ((sent < 3*DEPTH+1 || out_valid) && cycles < 300) begin
         step(sent < 3*DEPTH+1, 2'(sent % 4), 16'h8000 ^ 16'(sent * 16'h0111),
              1'($urandom_range(0, 1)));
         if (last_push) sent++;
         cycles++;
      end
      chk("wrap_budget", 32'(cycles < 300), 32'd1);
      chk("wrap_count", 32'(popped.size()), 32'(3*DEPTH+1));
      for (int i = 0; i < popped.size() && i < pushed.size(); i++)
         chk($sformatf("wrap_val%0d", i), popped[i], pushed[i]);

      // Asynchronous reset mid-run with 3 entries held
      for (int i = 0; i < 3; i++) step(1, 2'd1, 16'h0C00 + 16'(i), 0);
      chk("pre_rst_level", 32'(level), 32'd3);
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_level", 32'(level), 32'd0);
      chk("midrst_out_data", out_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 2'd0, 16'h0, 0);
      chk("post_rst_level", 32'(level), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
